// File: rtl/qed_consistency_checker_pkg.sv
// Shared QED definitions (package sys_defs): retire packet, fault causes,
// checker states and the pair-compare helper.
package sys_defs;

    // Bit of dest_reg_idx that separates original (x1-x15) from duplicate (x16-x31).
    localparam int QED_DUP_BIT = 4;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] result;
        logic [4:0]  dest_reg_idx;
        logic        valid;
    } MEM_WB_PACKET;

    typedef enum logic [1:0] {
        QF_NONE,
        QF_MISMATCH,
        QF_OVERFLOW,
        QF_TIMEOUT
    } QED_FAULT_CAUSE;

    typedef enum logic {
        QS_RUN,
        QS_FAULT
    } qed_state_e;

    // An original and its duplicate agree when they target the same
    // architectural register (low index bits) and carry the same result.
    function automatic logic qed_pair_mismatch(input MEM_WB_PACKET orig,
                                               input MEM_WB_PACKET dup);
        return (orig.dest_reg_idx[QED_DUP_BIT-1:0] != dup.dest_reg_idx[QED_DUP_BIT-1:0])
             | (orig.result != dup.result);
    endfunction

endpackage

// File: rtl/qed_pending_fifo.sv
// Pending-writeback FIFO. A pop and a push on the same edge are both
// honoured, so a full FIFO can accept a push while it pops.
module qed_pending_fifo
    import sys_defs::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  MEM_WB_PACKET           din,
    output MEM_WB_PACKET           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    MEM_WB_PACKET  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next pointers wrap naturally (DEPTH is a power of 2); count is exact.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy state; reset empties the queue at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/qed_consistency_checker.sv
// QED consistency checker: splits retiring writebacks into original and
// duplicate queues, pairs them in program order and compares each pair.
// Optional unmatched-entry watchdog enabled by defining QED_TIMEOUT_EN.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  QS_RUN   | classify/push retires, pop and compare head pairs
//  QS_FAULT | fault seen; queues frozen for debug until reset
module qed_consistency_checker
    import sys_defs::*;
#(
    parameter int Q_DEPTH        = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  MEM_WB_PACKET             wb_packet,
    output MEM_WB_PACKET             orig_out,
    output MEM_WB_PACKET             dup_out,
    output logic                     pair_valid,
    output logic                     fault,
    output logic                     fault_latched,
    output QED_FAULT_CAUSE           fault_cause,
    output logic [$clog2(Q_DEPTH):0] orig_count,
    output logic [$clog2(Q_DEPTH):0] dup_count
);

    if ((Q_DEPTH < 2) || ((Q_DEPTH & (Q_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("qed_consistency_checker: Q_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
    end

    qed_state_e     state_q, state_d;
    MEM_WB_PACKET   orig_out_q, orig_out_d;
    MEM_WB_PACKET   dup_out_q, dup_out_d;
    logic           pair_valid_q, pair_valid_d;
    logic           fault_q, fault_d;
    logic           fault_latched_q, fault_latched_d;
    QED_FAULT_CAUSE fault_cause_q, fault_cause_d;

    MEM_WB_PACKET   orig_head, dup_head;
    logic           orig_full, orig_empty, dup_full, dup_empty;
    logic           in_run, pkt_take, pkt_is_dup;
    logic           pair_ready, orig_want, dup_want;
    logic           orig_push, dup_push;
    logic           mismatch_det, overflow_det, timeout_det;

    assign in_run     = (state_q == QS_RUN);
    assign pkt_take   = wb_packet.valid && (wb_packet.dest_reg_idx != '0);
    assign pkt_is_dup = wb_packet.dest_reg_idx[QED_DUP_BIT];

    // Both heads present: this edge pops and compares them.
    assign pair_ready = in_run && !orig_empty && !dup_empty;
    assign orig_want  = in_run && pkt_take && !pkt_is_dup;
    assign dup_want   = in_run && pkt_take && pkt_is_dup;

    // The pop frees a slot before the push lands, so a full queue that is
    // popping can still accept; otherwise the packet is dropped.
    assign orig_push  = orig_want && (!orig_full || pair_ready);
    assign dup_push   = dup_want  && (!dup_full  || pair_ready);

    assign mismatch_det = pair_ready && qed_pair_mismatch(orig_head, dup_head);
    assign overflow_det = (orig_want && orig_full && !pair_ready)
                        | (dup_want  && dup_full  && !pair_ready);

    qed_pending_fifo #(.DEPTH(Q_DEPTH)) u_orig_q (
        .clk   (clk),
        .reset (reset),
        .push  (orig_push),
        .pop   (pair_ready),
        .din   (wb_packet),
        .head  (orig_head),
        .full  (orig_full),
        .empty (orig_empty),
        .count (orig_count)
    );

    qed_pending_fifo #(.DEPTH(Q_DEPTH)) u_dup_q (
        .clk   (clk),
        .reset (reset),
        .push  (dup_push),
        .pop   (pair_ready),
        .din   (wb_packet),
        .head  (dup_head),
        .full  (dup_full),
        .empty (dup_empty),
        .count (dup_count)
    );

`ifdef QED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            one_pending;

    assign one_pending = (orig_empty != dup_empty);
    // Fires on the cycle whose increment would reach TIMEOUT_CYCLES.
    assign timeout_det = in_run && one_pending && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts cycles spent with an unmatched entry; frozen in FAULT.
    always_comb begin
        wd_d = wd_q;
        if (in_run) begin
            if (pair_ready || (orig_empty && dup_empty)) wd_d = '0;
            else if (one_pending)                        wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`else
    assign timeout_det = 1'b0;
`endif

    // Next state, registered pair outputs and first-fault capture.
    always_comb begin
        state_d         = state_q;
        orig_out_d      = '0;
        dup_out_d       = '0;
        pair_valid_d    = 1'b0;
        fault_d         = 1'b0;
        fault_latched_d = fault_latched_q;
        fault_cause_d   = fault_cause_q;
        case (state_q)
            QS_RUN: begin
                if (pair_ready) begin
                    orig_out_d   = orig_head;
                    dup_out_d    = dup_head;
                    pair_valid_d = 1'b1;
                end
                if (mismatch_det || overflow_det || timeout_det) begin
                    state_d         = QS_FAULT;
                    fault_d         = 1'b1;
                    fault_latched_d = 1'b1;
                    if (mismatch_det)      fault_cause_d = QF_MISMATCH;
                    else if (overflow_det) fault_cause_d = QF_OVERFLOW;
                    else                   fault_cause_d = QF_TIMEOUT;
                end
            end
            QS_FAULT: begin
                state_d = QS_FAULT;
            end
            default: begin
                state_d = QS_RUN;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= QS_RUN;
            orig_out_q      <= '0;
            dup_out_q       <= '0;
            pair_valid_q    <= 1'b0;
            fault_q         <= 1'b0;
            fault_latched_q <= 1'b0;
            fault_cause_q   <= QF_NONE;
        end else begin
            state_q         <= state_d;
            orig_out_q      <= orig_out_d;
            dup_out_q       <= dup_out_d;
            pair_valid_q    <= pair_valid_d;
            fault_q         <= fault_d;
            fault_latched_q <= fault_latched_d;
            fault_cause_q   <= fault_cause_d;
        end
    end

    assign orig_out      = orig_out_q;
    assign dup_out       = dup_out_q;
    assign pair_valid    = pair_valid_q;
    assign fault         = fault_q;
    assign fault_latched = fault_latched_q;
    assign fault_cause   = fault_cause_q;

endmodule

// File: tb/tb_qed_consistency_checker.sv
// Directed bench for qed_consistency_checker. Inputs change and outputs are
// sampled on the falling edge; all outputs of the DUT are registered.
module tb_qed_consistency_checker;
    import sys_defs::*;

    logic           clk;
    logic           reset;
    MEM_WB_PACKET   wb_packet;
    MEM_WB_PACKET   orig_out, dup_out;
    logic           pair_valid, fault, fault_latched;
    QED_FAULT_CAUSE fault_cause;
    logic [4:0]     orig_count, dup_count;

    int checks   = 0;
    int failures = 0;

    qed_consistency_checker #(.Q_DEPTH(16), .TIMEOUT_CYCLES(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_packet     (wb_packet),
        .orig_out      (orig_out),
        .dup_out       (dup_out),
        .pair_valid    (pair_valid),
        .fault         (fault),
        .fault_latched (fault_latched),
        .fault_cause   (fault_cause),
        .orig_count    (orig_count),
        .dup_count     (dup_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic MEM_WB_PACKET mk(input logic [4:0] idx, input logic [31:0] res);
        MEM_WB_PACKET p;
        p.npc          = 32'h0000_1000 + {27'd0, idx};
        p.result       = res;
        p.dest_reg_idx = idx;
        p.valid        = 1'b1;
        return p;
    endfunction

    // Present one packet for the next rising edge.
    task automatic step(input MEM_WB_PACKET p);
        @(negedge clk);
        wb_packet = p;
    endtask

    task automatic idle();
        step('0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        wb_packet = '0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic pv_seen;
        int   wait_n;
        reset     = 1'b1;
        wb_packet = '0;
        @(negedge clk);
        check("rst_pair_valid", 64'(pair_valid), 64'd0);
        check("rst_fault", 64'({fault, fault_latched}), 64'd0);
        check("rst_cause", 64'(fault_cause), 64'(QF_NONE));
        check("rst_counts", 64'({orig_count, dup_count}), 64'd0);
        check("rst_orig_out", 64'(orig_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: matching pair, output two cycles after the completing packet
        step(mk(5'd5, 32'h1234));
        step(mk(5'd21, 32'h1234));
        idle();
        check("t1_counts_pending", 64'({orig_count, dup_count}), {54'd0, 5'd1, 5'd1});
        check("t1_no_early_pv", 64'(pair_valid), 64'd0);
        idle();
        check("t1_pair_valid", 64'(pair_valid), 64'd1);
        check("t1_fault", 64'(fault), 64'd0);
        check("t1_orig_result", 64'(orig_out.result), 64'h1234);
        check("t1_dup_idx", 64'(dup_out.dest_reg_idx), 64'd21);
        check("t1_counts_zero", 64'({orig_count, dup_count}), 64'd0);
        idle();
        check("t1_pv_drop", 64'(pair_valid), 64'd0);
        check("t1_out_zero", 64'(orig_out) | 64'(dup_out), 64'd0);

        // 2: result mismatch, then FAULT stops all comparison
        do_reset();
        step(mk(5'd5, 32'h1234));
        step(mk(5'd21, 32'h1235));
        idle();
        idle();
        check("t2_pair_valid", 64'(pair_valid), 64'd1);
        check("t2_fault", 64'(fault), 64'd1);
        check("t2_cause", 64'(fault_cause), 64'(QF_MISMATCH));
        idle();
        check("t2_fault_pulse", 64'(fault), 64'd0);
        check("t2_latched", 64'(fault_latched), 64'd1);
        step(mk(5'd6, 32'h55));
        step(mk(5'd22, 32'h55));
        pv_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle();
            pv_seen = pv_seen | pair_valid | fault;
        end
        check("t2_frozen_pv", 64'(pv_seen), 64'd0);
        check("t2_frozen_counts", 64'({orig_count, dup_count}), 64'd0);
        check("t2_cause_held", 64'(fault_cause), 64'(QF_MISMATCH));

        // 3: overflow on the 17th original with no duplicate
        do_reset();
        for (int i = 0; i < 16; i++) step(mk(5'(1 + i % 15), 32'(i)));
        step(mk(5'd4, 32'hDEAD));
        check("t3_full_count", 64'(orig_count), 64'd16);
        check("t3_no_fault_yet", 64'(fault), 64'd0);
        idle();
        check("t3_fault", 64'(fault), 64'd1);
        check("t3_cause", 64'(fault_cause), 64'(QF_OVERFLOW));
        check("t3_count_held", 64'(orig_count), 64'd16);

        // mid-run asynchronous reset discards the full queue immediately
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_counts", 64'({orig_count, dup_count}), 64'd0);
        check("rst_mid_latched", 64'(fault_latched), 64'd0);
        check("rst_mid_cause", 64'(fault_cause), 64'(QF_NONE));
        @(negedge clk);
        reset = 1'b0;

        // 4: full queue pops on the same edge the 17th original arrives
        for (int i = 0; i < 16; i++) step(mk(5'(1 + i % 15), 32'(100 + i)));
        step(mk(5'd17, 32'd100));
        check("t4_full", 64'(orig_count), 64'd16);
        step(mk(5'd2, 32'd200));
        check("t4_dup_pending", 64'(dup_count), 64'd1);
        idle();
        check("t4_no_fault", 64'({fault, fault_latched}), 64'd0);
        check("t4_pair_valid", 64'(pair_valid), 64'd1);
        check("t4_orig_result", 64'(orig_out.result), 64'd100);
        check("t4_counts", 64'({orig_count, dup_count}), {54'd0, 5'd16, 5'd0});

        // 5: x0 writes and invalid packets are ignored
        do_reset();
        step(mk(5'd0, 32'h77));
        wb_packet = mk(5'd5, 32'h77);
        wb_packet.valid = 1'b0;
        step(wb_packet);
        wb_packet = mk(5'd21, 32'h77);
        wb_packet.valid = 1'b0;
        step(wb_packet);
        idle();
        idle();
        check("t5_counts", 64'({orig_count, dup_count}), 64'd0);
        check("t5_no_output", 64'({pair_valid, fault}), 64'd0);

        // 7: burst of two pairs, second differs only in destination register
        do_reset();
        step(mk(5'd7, 32'hAA));
        step(mk(5'd8, 32'hBB));
        step(mk(5'd23, 32'hAA));
        step(mk(5'd25, 32'hBB));
        idle();
        check("t7_first_pv", 64'({pair_valid, fault}), 64'b10);
        check("t7_first_orig", 64'(orig_out.result), 64'hAA);
        idle();
        check("t7_second_fault", 64'({pair_valid, fault}), 64'b11);
        check("t7_second_idx", 64'(orig_out.dest_reg_idx), 64'd8);
        check("t7_cause", 64'(fault_cause), 64'(QF_MISMATCH));

        // 6: unmatched original and the watchdog
        do_reset();
        step(mk(5'd3, 32'h33));
        wait_n = 0;
`ifdef QED_TIMEOUT_EN
        for (int i = 1; i <= 100; i++) begin
            idle();
            if (fault) begin
                wait_n = i;
                break;
            end
        end
        check("t6_timeout_cycle", 64'(wait_n), 64'd65);
        check("t6_cause", 64'(fault_cause), 64'(QF_TIMEOUT));
`else
        for (int i = 1; i <= 100; i++) begin
            idle();
            if (fault_latched) wait_n = i;
        end
        check("t6_no_timeout", 64'(wait_n), 64'd0);
        check("t6_pending", 64'(orig_count), 64'd1);
`endif
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_counts", 64'({orig_count, dup_count}), 64'd0);
        check("t6_rst_latched", 64'(fault_latched), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step(mk(5'd9, 32'h99));
        step(mk(5'd25, 32'h99));
        idle();
        idle();
        check("t6_resume_pv", 64'({pair_valid, fault}), 64'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
